export_dma: RTL and testbench

EXPORT_DMA -- requirements
Module: export_dma

---
 rtl/export_dma_pkg.sv | 25 ++
 rtl/export_dma.sv | 159 +++++++++++++++
 tb/tb_export_dma.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/export_dma_pkg.sv
// Shared state encoding, command constants and state-class helper for the
// export-port DMA engine.
package export_dma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RD_REQ  = 3'd2,
    RD_CAP  = 3'd3,
    RD_SEND = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic CMD_LOAD = 1'b1;
  localparam logic CMD_DUMP = 1'b0;

  // States in which the engine owns the data memory export port.
  function automatic logic is_xfer_state(input state_t s);
    case (s)
      LOAD, RD_REQ, RD_CAP, RD_SEND: is_xfer_state = 1'b1;
      default:                       is_xfer_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/export_dma.sv
// DMA engine moving words between a load/dump stream pair and a data memory
// reached through its export port (registered, one-cycle read latency).
module export_dma
  import export_dma_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DATA_A = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [DATA_A-1:0] cmd_base,
  input  logic [DATA_A:0]   cmd_count,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              exp_en,
  output logic [DATA_A-1:0] exp_address,
  output logic [DATA_W-1:0] exp_data,
  output logic              exp_MR,
  output logic              exp_MW,
  input  logic [DATA_W-1:0] exp_out
);

  localparam logic [DATA_A-1:0] ADDR_ONE  = {{(DATA_A-1){1'b0}}, 1'b1};
  localparam logic [DATA_A:0]   REM_ONE   = {{DATA_A{1'b0}}, 1'b1};
  localparam logic [DATA_A:0]   REM_ZERO  = {(DATA_A+1){1'b0}};

  state_t            state_q, state_d;
  logic [DATA_A-1:0] addr_q, addr_d;
  logic [DATA_A:0]   remaining_q, remaining_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic live_s;
  logic load_hs_s;
  logic send_hs_s;

  // Handshake qualifiers; reset outranks every handshake in its own cycle.
  always_comb begin
    live_s    = ~reset;
    load_hs_s = (state_q == LOAD) && (write_q == CMD_LOAD) && in_valid;
    send_hs_s = (state_q == RD_SEND) && out_ready;
  end

  // Next-state, address and remaining-count update.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    write_d     = write_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_base;
          remaining_d = cmd_count;
          write_d     = cmd_write;
          if (cmd_count == REM_ZERO) begin
            state_d = DONE;
          end else if (cmd_write == CMD_LOAD) begin
            state_d = LOAD;
          end else begin
            state_d = RD_REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // A write coinciding with abort still lands, so counters advance too.
        if (load_hs_s) begin
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
        end else begin
          addr_d      = addr_q;
        end
        if (abort || (load_hs_s && (remaining_q == REM_ONE))) begin
          state_d = DONE;
        end else begin
          state_d = LOAD;
        end
      end
      RD_REQ: begin
        if (abort) begin
          state_d = DONE;
        end else begin
          state_d = RD_CAP;
        end
      end
      RD_CAP: begin
        out_data_d = exp_out;
        if (abort) begin
          state_d = DONE;
        end else begin
          state_d = RD_SEND;
        end
      end
      RD_SEND: begin
        if (abort) begin
          state_d = DONE;
        end else if (send_hs_s) begin
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d = DONE;
          end else begin
            state_d = RD_REQ;
          end
        end else begin
          state_d = RD_SEND;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    cmd_ready   = live_s && (state_q == IDLE);
    busy        = (state_q != IDLE);
    done        = live_s && (state_q == DONE);
    exp_en      = live_s && is_xfer_state(state_q);
    in_ready    = live_s && (state_q == LOAD);
    exp_MW      = live_s && load_hs_s;
    exp_MR      = live_s && (state_q == RD_REQ) && (write_q == CMD_DUMP);
    out_valid   = live_s && (state_q == RD_SEND);
    out_data    = out_data_q;
    exp_address = exp_en ? addr_q : {DATA_A{1'b0}};
    exp_data    = exp_MW ? in_data : {DATA_W{1'b0}};
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= {DATA_A{1'b0}};
      remaining_q <= REM_ZERO;
      write_q     <= CMD_DUMP;
      out_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      write_q     <= write_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_export_dma.sv
// Self-checking bench for export_dma: table of whole commands plus hand-written
// back-pressure, abort and mid-transfer reset sequences against a memory model.
module tb_export_dma;
  import export_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, cmd_write, abort;
  logic [10:0] cmd_base;
  logic [11:0] cmd_count;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic        busy, done, exp_en, exp_MR, exp_MW;
  logic [10:0] exp_address;
  logic [15:0] exp_data, exp_out;

  always #5 clk = ~clk;

  export_dma #(.DATA_W(16), .DATA_A(11)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_base(cmd_base), .cmd_count(cmd_count), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .exp_en(exp_en), .exp_address(exp_address),
    .exp_data(exp_data), .exp_MR(exp_MR), .exp_MW(exp_MW), .exp_out(exp_out)
  );

  // Data memory model with registered read.
  logic        mem_init;
  logic [15:0] mem [0:2047];
  logic [15:0] rd_q;
  logic [15:0] in_hs_cnt, hs_start, cur_first;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'h0000;
      rd_q      <= 16'h0000;
      in_hs_cnt <= 16'd0;
    end else begin
      if (exp_en && exp_MW) mem[exp_address] <= exp_data;
      if (exp_en && exp_MR) rd_q <= mem[exp_address];
      if (in_valid && in_ready) in_hs_cnt <= in_hs_cnt + 16'd1;
    end
  end
  assign exp_out = rd_q;
  assign in_data = in_valid ? 16'(cur_first + (in_hs_cnt - hs_start)) : 16'h0000;

  // Monitor sampling on the falling edge.
  int cyc, en_cnt, mr_cnt, done_cnt, bad_strobe, hs_cyc, done_cyc;
  logic [10:0] a_log [$];
  logic [15:0] d_log [$];
  int          c_log [$];
  always @(negedge clk) begin
    if (exp_en) en_cnt++;
    if (exp_MR) begin mr_cnt++; a_log.push_back(exp_address); end
    if (exp_MW) begin a_log.push_back(exp_address); d_log.push_back(exp_data); c_log.push_back(cyc); end
    if (out_valid && out_ready) begin d_log.push_back(out_data); c_log.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cmd_valid && cmd_ready) hs_cyc = cyc;
    if ((exp_MR && exp_MW) || ((exp_MR || exp_MW) && !exp_en)) bad_strobe++;
    cyc++;
  end

  int n_checks, n_errors;
  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);        chk({tag, "_done"}, done, 0);
    chk({tag, "_out_valid"}, out_valid, 0); chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_exp_en"}, exp_en, 0);    chk({tag, "_exp_MR"}, exp_MR, 0);
    chk({tag, "_exp_MW"}, exp_MW, 0);    chk({tag, "_exp_address"}, exp_address, 0);
    chk({tag, "_exp_data"}, exp_data, 0); chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  typedef struct {
    logic        wr;
    logic [10:0] base;
    logic [11:0] count;
    logic [15:0] first;
    int          first_off;
    int          spacing;
    int          done_off;
  } vec_t;
  vec_t vecs [7];

  task automatic issue(input logic wr, input logic [10:0] base, input logic [11:0] count,
                       input logic [15:0] first);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_base = base; cmd_count = count;
    in_valid = wr; cur_first = first; hs_start = in_hs_cnt; out_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int a0, d0, en0, mr0, dn0, n_exp, bad, exp_c;
    bit seen;
    logic [10:0] exp_a;
    logic [15:0] exp_d;
    v = vecs[idx];
    a0 = a_log.size(); d0 = d_log.size(); en0 = en_cnt; mr0 = mr_cnt; dn0 = done_cnt;
    issue(v.wr, v.base, v.count, v.first);
    seen = 1'b0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_done_seen", idx), seen, 1);
    chk($sformatf("v%0d_ready_after_done", idx), cmd_ready, 1);
    chk($sformatf("v%0d_done_one_cycle", idx), done, 0);
    chk($sformatf("v%0d_done_pulses", idx), done_cnt - dn0, 1);
    chk($sformatf("v%0d_done_latency", idx), done_cyc - hs_cyc, v.done_off);
    n_exp = int'(v.count);
    chk($sformatf("v%0d_exp_en_cycles", idx), en_cnt - en0, v.wr ? n_exp : 3 * n_exp);
    chk($sformatf("v%0d_mr_count", idx), mr_cnt - mr0, v.wr ? 0 : n_exp);
    chk($sformatf("v%0d_strobe_count", idx), a_log.size() - a0, n_exp);
    chk($sformatf("v%0d_word_count", idx), d_log.size() - d0, n_exp);
    bad = 0;
    for (int i = 0; i < n_exp; i++) begin
      if ((a0 + i < a_log.size()) && (d0 + i < d_log.size())) begin
        exp_a = 11'(int'(v.base) + i);
        exp_d = 16'(int'(v.first) + i);
        exp_c = hs_cyc + v.first_off + i * v.spacing;
        if (a_log[a0+i] !== exp_a || d_log[d0+i] !== exp_d || c_log[d0+i] != exp_c) begin
          if (bad == 0)
            $display("  v%0d word %0d: addr %h want %h, data %h want %h, cycle %0d want %0d",
                     idx, i, a_log[a0+i], exp_a, d_log[d0+i], exp_d, c_log[d0+i], exp_c);
          bad++;
        end
      end else begin
        bad++;
      end
    end
    chk($sformatf("v%0d_stream_errs", idx), bad, 0);
  endtask

  initial begin
    int d0, mr0, dn0, a0, stall_left;
    bit seen, stalling, aborted, hit;

    vecs[0] = '{1'b1, 11'h005, 12'h800, 16'h1000, 1, 1, 2049};
    vecs[1] = '{1'b1, 11'h010, 12'd4,   16'hA001, 1, 1, 5};
    vecs[2] = '{1'b0, 11'h010, 12'd4,   16'hA001, 3, 3, 13};
    vecs[3] = '{1'b1, 11'h7FE, 12'd3,   16'hB001, 1, 1, 4};
    vecs[4] = '{1'b0, 11'h7FE, 12'd3,   16'hB001, 3, 3, 10};
    vecs[5] = '{1'b0, 11'h100, 12'd0,   16'h0000, 0, 0, 1};
    vecs[6] = '{1'b1, 11'h100, 12'd0,   16'h0000, 0, 0, 1};

    reset = 1'b1; mem_init = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_base = 11'h000; cmd_count = 12'd0; abort = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; cur_first = 16'h0000; hs_start = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready_low", cmd_ready, 0);
    reset = 1'b0; mem_init = 1'b0;
    #1;
    chk_idle("por");

    for (int i = 0; i < 7; i++) run_vec(i);
    chk("wrap_word_at_0x000", mem[0], 16'hB003);

    // Back-pressure: out_ready low for 5 cycles while word 2 is offered.
    d0 = d_log.size(); mr0 = mr_cnt; dn0 = done_cnt;
    issue(CMD_DUMP, 11'h010, 12'd4, 16'h0000);
    stall_left = 5; stalling = 1'b0; seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (stall_left > 0 && (stalling || (out_valid && (d_log.size() - d0 == 1)))) begin
        stalling = 1'b1; out_ready = 1'b0; stall_left--;
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, 16'hA002);
        chk("stall_no_mr", exp_MR, 0);
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_done_seen", seen, 1);
    chk("stall_stalled_5", stall_left, 0);
    chk("stall_words", d_log.size() - d0, 4);
    for (int i = 0; i < 4; i++)
      if (d0 + i < d_log.size()) chk($sformatf("stall_word%0d", i), d_log[d0+i], 16'hA001 + i);
    chk("stall_mr_count", mr_cnt - mr0, 4);
    chk("stall_done_pulses", done_cnt - dn0, 1);

    // Abort while word 2 of an 8-word dump is being offered.
    d0 = d_log.size(); mr0 = mr_cnt;
    issue(CMD_DUMP, 11'h010, 12'd8, 16'h0000);
    aborted = 1'b0;
    for (int k = 0; k < 200 && !aborted; k++) begin
      if (out_valid && (d_log.size() - d0 == 1)) begin
        out_ready = 1'b0; abort = 1'b1; aborted = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0; out_ready = 1'b1;
    chk("abort_seen", aborted, 1);
    chk("abort_done", done, 1);
    chk("abort_out_valid_dropped", out_valid, 0);
    chk("abort_no_exp_en", exp_en, 0);
    chk("abort_no_strobe", exp_MR | exp_MW, 0);
    @(posedge clk); #1;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_cmd_ready", cmd_ready, 1);
    chk("abort_words", d_log.size() - d0, 1);
    if (d0 < d_log.size()) chk("abort_word1", d_log[d0], 16'hA001);
    chk("abort_mr_count", mr_cnt - mr0, 2);

    // Reset after three words of a six-word load.
    a0 = a_log.size();
    issue(CMD_LOAD, 11'h020, 12'd6, 16'hC001);
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      if (a_log.size() - a0 == 3) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    reset = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_hit", hit, 1);
    chk("rst_cycle_cmd_ready", cmd_ready, 0);
    chk("rst_cycle_no_mw", exp_MW, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk_idle("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("rst_writes", a_log.size() - a0, 3);
    chk("rst_mem20", mem[11'h020], 16'hC001);
    chk("rst_mem21", mem[11'h021], 16'hC002);
    chk("rst_mem22", mem[11'h022], 16'hC003);
    chk("rst_mem23_untouched", mem[11'h023], 16'h101E);
    chk("strobe_exclusive", bad_strobe, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
